// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding, header layout,
// frame length and the fixed bytes/words the decoder emits.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR_DONE = 2'd1,
        ST_DATA_HI  = 2'd2,
        ST_DATA_LO  = 2'd3
    } state_e;

    localparam int          RW_BIT    = 7;
    localparam int          FRAME_LEN = 3;
    localparam logic [15:0] BAD_READ  = 16'hFFFF;
    localparam logic [7:0]  IDLE_TX   = 8'h00;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge detector.
// Flops reset high so a line that idles high produces no edge out of reset.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_rise = sync_q & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes 3-byte SPI frames {RW,ADDR},DATA_HI,DATA_LO into register read/write
// strobes and schedules the MISO bytes (read data, then idle filler).
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    input  logic        i_SPI_CS_n,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_Byte,
    output logic [6:0]  o_Addr,
    output logic        o_Wr_En,
    output logic [15:0] o_Wr_Data,
    output logic        o_Rd_En,
    input  logic [15:0] i_Rd_Data,
    output logic        o_Err,
    output logic [7:0]  o_Err_Count
);

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic frame_end;

    sync_edge_det u_cs_sync (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .i_async (i_SPI_CS_n),
        .o_rise  (frame_end)
    );

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic        bad_q, bad_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        rd_en_q, rd_en_d;
    logic [1:0]  rd_wait_q, rd_wait_d;
    logic [15:0] shadow_q, shadow_d;
    logic        hi_pend_q, hi_pend_d;
    logic        lo_pend_q, lo_pend_d;
    logic        zero_pend_q, zero_pend_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        err_q, err_d;
    logic        err_pend_q, err_pend_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic byte_ok, abort, hdr_bad, cap_now;
    logic hi_req, lo_req, zero_req, err_req;

    // A frame-end beats a byte arriving in the same cycle.
    assign byte_ok = i_RX_DV & ~frame_end;
    assign abort   = frame_end & (state_q != ST_IDLE);
    assign hdr_bad = ({1'b0, i_RX_Byte[6:0]} >= NUM_REGS_W);
    assign cap_now = (rd_wait_q == 2'd1);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        bad_d       = bad_q;
        addr_d      = addr_q;
        data_hi_d   = data_hi_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_wait_d   = rd_wait_q;
        shadow_d    = shadow_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        hi_req      = hi_pend_q;
        lo_req      = lo_pend_q;
        zero_req    = zero_pend_q;
        err_req     = err_pend_q;

        // Read data arrives the cycle after the read strobe.
        if (rd_wait_q != 2'd0) rd_wait_d = rd_wait_q - 2'd1;
        if (cap_now) begin
            shadow_d = bad_q ? BAD_READ : i_Rd_Data;
            hi_req   = 1'b1;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            rd_wait_d = 2'd0;
            hi_req    = 1'b0;
            lo_req    = 1'b0;
            zero_req  = 1'b1;
            err_req   = 1'b1;
        end else if (byte_ok) begin
            case (state_q)
                ST_IDLE: begin
                    addr_d  = i_RX_Byte[6:0];
                    rw_d    = i_RX_Byte[RW_BIT];
                    bad_d   = hdr_bad;
                    state_d = ST_DATA_HI;
                    if (hdr_bad) err_req = 1'b1;
                    if (i_RX_Byte[RW_BIT]) begin
                        rd_en_d   = ~hdr_bad;
                        rd_wait_d = 2'd2;
                    end
                end
                ST_DATA_HI: begin
                    state_d = ST_DATA_LO;
                    if (rw_q) lo_req = 1'b1;
                    else      data_hi_d = i_RX_Byte;
                end
                ST_DATA_LO: begin
                    state_d  = ST_IDLE;
                    zero_req = 1'b1;
                    if (!rw_q && !bad_q) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {data_hi_q, i_RX_Byte};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // One TX pulse at most every other cycle; read bytes go out before the filler.
        if (!tx_dv_q) begin
            if (hi_req) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = shadow_d[15:8];
                hi_req    = 1'b0;
            end else if (lo_req && rd_wait_d == 2'd0) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = shadow_d[7:0];
                lo_req    = 1'b0;
            end else if (zero_req && !lo_req && rd_wait_d == 2'd0) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = IDLE_TX;
                zero_req  = 1'b0;
            end
        end

        if (err_req && !err_q) begin
            err_d   = 1'b1;
            err_req = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end

        hi_pend_d   = hi_req;
        lo_pend_d   = lo_req;
        zero_pend_d = zero_req;
        err_pend_d  = err_req;
    end

    // NOTE: the 16-bit shadow is a plain register (not a memory), so it is reset with everything else.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            bad_q       <= 1'b0;
            addr_q      <= '0;
            data_hi_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_wait_q   <= '0;
            shadow_q    <= '0;
            hi_pend_q   <= 1'b0;
            lo_pend_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            bad_q       <= bad_d;
            addr_q      <= addr_d;
            data_hi_q   <= data_hi_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_wait_q   <= rd_wait_d;
            shadow_q    <= shadow_d;
            hi_pend_q   <= hi_pend_d;
            lo_pend_q   <= lo_pend_d;
            zero_pend_q <= zero_pend_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Addr      = addr_q;
    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Rd_En     = rd_en_q;
    assign o_Err       = err_q;
    assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: writes, reads, bad addresses, aborts,
// reset mid-frame and error-counter saturation.
module tb_spi_cmd_decoder;
    import spi_cmd_pkg::*;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = 8'h00;
    logic        i_SPI_CS_n = 1'b1;
    logic [15:0] i_Rd_Data = 16'h0000;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic [6:0]  o_Addr;
    logic        o_Wr_En;
    logic [15:0] o_Wr_Data;
    logic        o_Rd_En;
    logic        o_Err;
    logic [7:0]  o_Err_Count;

    int passed = 0;
    int total  = 0;

    spi_cmd_decoder #(.NUM_REGS(16)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .i_SPI_CS_n  (i_SPI_CS_n),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Addr      (o_Addr),
        .o_Wr_En     (o_Wr_En),
        .o_Wr_Data   (o_Wr_Data),
        .o_Rd_En     (o_Rd_En),
        .i_Rd_Data   (i_Rd_Data),
        .o_Err       (o_Err),
        .o_Err_Count (o_Err_Count)
    );

    always #5 i_Clk = ~i_Clk;

    // Pulse monitor, sampled on the falling edge.
    int         wr_seen = 0;
    int         err_seen = 0;
    int         viol = 0;
    logic [7:0] tx_log[$];
    logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_tx = 1'b0, prev_err = 1'b0;

    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            if (o_Wr_En) wr_seen++;
            if (o_Err)   err_seen++;
            if (o_TX_DV) tx_log.push_back(o_TX_Byte);
            if ((o_Wr_En && prev_wr) || (o_Rd_En && prev_rd) ||
                (o_TX_DV && prev_tx) || (o_Err && prev_err)) viol++;
        end
        prev_wr  = o_Wr_En;
        prev_rd  = o_Rd_En;
        prev_tx  = o_TX_DV;
        prev_err = o_Err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    // Byte valid for one cycle; returns one cycle after it (registered-output time).
    task automatic send_byte(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        tick(1);
        i_RX_DV   = 1'b0;
    endtask

    task automatic cs_low();
        i_SPI_CS_n = 1'b0;
        tick(3);
    endtask

    task automatic cs_high();
        i_SPI_CS_n = 1'b1;
        tick(6);
    endtask

    int wr_base, err_base, tx_base;

    initial begin
        tick(3);
        check("rst_tx_dv",  o_TX_DV, 0);
        check("rst_tx_byte", o_TX_Byte, 0);
        check("rst_addr",   o_Addr, 0);
        check("rst_wr_en",  o_Wr_En, 0);
        check("rst_wr_data", o_Wr_Data, 0);
        check("rst_rd_en",  o_Rd_En, 0);
        check("rst_err",    o_Err, 0);
        check("rst_err_cnt", o_Err_Count, 0);
        i_Rst = 1'b0;
        tick(4);

        // Write 0x05,0x12,0x34
        wr_base = wr_seen; err_base = err_seen;
        cs_low();
        send_byte(8'h05); tick(2);
        send_byte(8'h12); tick(2);
        send_byte(8'h34);
        check("wr_en",      o_Wr_En, 1);
        check("wr_addr",    o_Addr, 5);
        check("wr_data",    o_Wr_Data, 16'h1234);
        check("wr_tx_dv",   o_TX_DV, 1);
        check("wr_tx_zero", o_TX_Byte, 8'h00);
        tick(1);
        check("wr_en_drop", o_Wr_En, 0);
        cs_high();
        check("wr_count",   wr_seen - wr_base, 1);
        check("wr_no_err",  err_seen - err_base, 0);

        // Read 0x83 with 0xBEEF on the read port only during T+2
        wr_base = wr_seen;
        cs_low();
        send_byte(8'h83);
        check("rd_en_t1",   o_Rd_En, 1);
        check("rd_addr",    o_Addr, 3);
        check("rd_tx_t1",   o_TX_DV, 0);
        tick(1);
        check("rd_en_t2",   o_Rd_En, 0);
        check("rd_tx_t2",   o_TX_DV, 0);
        i_Rd_Data = 16'hBEEF;
        tick(1);
        i_Rd_Data = 16'h0000;
        check("rd_tx_t3",   o_TX_DV, 1);
        check("rd_hi",      o_TX_Byte, 8'hBE);
        tick(2);
        send_byte(8'h55);
        check("rd_lo_dv",   o_TX_DV, 1);
        check("rd_lo",      o_TX_Byte, 8'hEF);
        tick(2);
        send_byte(8'h66);
        check("rd_end_dv",  o_TX_DV, 1);
        check("rd_end",     o_TX_Byte, 8'h00);
        check("rd_no_wr",   o_Wr_En, 0);
        cs_high();
        check("rd_wr_count", wr_seen - wr_base, 0);

        // Out-of-range write 0x20, then out-of-range read 0xA0
        wr_base = wr_seen;
        cs_low();
        send_byte(8'h20);
        check("bad_wr_err", o_Err, 1);
        check("bad_wr_cnt", o_Err_Count, 1);
        tick(1);
        check("bad_wr_err_drop", o_Err, 0);
        for (int i = 1; i < FRAME_LEN; i++) begin
            tick(2);
            send_byte(8'h77);
        end
        check("bad_wr_tx",  o_TX_Byte, 8'h00);
        cs_high();
        check("bad_wr_none", wr_seen - wr_base, 0);

        i_Rd_Data = 16'h1234;
        cs_low();
        send_byte(8'hA0);
        check("bad_rd_err", o_Err, 1);
        check("bad_rd_en",  o_Rd_En, 0);
        check("bad_rd_cnt", o_Err_Count, 2);
        tick(2);
        check("bad_rd_hi",  o_TX_Byte, 8'hFF);
        tick(2);
        send_byte(8'h00);
        check("bad_rd_lo",  o_TX_Byte, 8'hFF);
        i_Rd_Data = 16'h0000;
        tick(2);
        send_byte(8'h00);
        check("bad_rd_end", o_TX_Byte, 8'h00);
        cs_high();

        // Abort after two write bytes, then a clean write
        wr_base = wr_seen; err_base = err_seen;
        cs_low();
        send_byte(8'h05); tick(2);
        send_byte(8'h12); tick(2);
        cs_high();
        check("abort_err",  err_seen - err_base, 1);
        check("abort_no_wr", wr_seen - wr_base, 0);
        check("abort_cnt",  o_Err_Count, 3);
        check("abort_tx",   tx_log[tx_log.size() - 1], 8'h00);
        cs_low();
        send_byte(8'h01); tick(2);
        send_byte(8'hAB); tick(2);
        send_byte(8'hCD);
        check("post_wr_en", o_Wr_En, 1);
        check("post_addr",  o_Addr, 1);
        check("post_data",  o_Wr_Data, 16'hABCD);
        cs_high();

        // Back-to-back read bytes while the shadow is still pending
        tx_base = tx_log.size();
        cs_low();
        send_byte(8'h82);
        send_byte(8'h11);
        i_Rd_Data = 16'hC3A5;
        tick(1);
        i_Rd_Data = 16'h0000;
        check("fast_hi_dv", o_TX_DV, 1);
        check("fast_hi",    o_TX_Byte, 8'hC3);
        tick(4);
        send_byte(8'h22);
        tick(4);
        cs_high();
        check("fast_tx_n",  tx_log.size() - tx_base, 3);
        if (tx_log.size() - tx_base == 3) begin
            check("fast_tx0", tx_log[tx_base],     8'hC3);
            check("fast_tx1", tx_log[tx_base + 1], 8'hA5);
            check("fast_tx2", tx_log[tx_base + 2], 8'h00);
        end

        // Reset after two write bytes
        cs_low();
        send_byte(8'h05); tick(1);
        send_byte(8'h12); tick(1);
        i_Rst = 1'b1;
        #1;
        check("mid_rst_addr",  o_Addr, 0);
        check("mid_rst_data",  o_Wr_Data, 0);
        check("mid_rst_tx",    o_TX_Byte, 0);
        check("mid_rst_cnt",   o_Err_Count, 0);
        tick(2);
        i_Rst = 1'b0;
        wr_base = wr_seen; err_base = err_seen;
        tick(2);
        cs_high();
        check("mid_rst_no_wr",  wr_seen - wr_base, 0);
        check("mid_rst_no_err", err_seen - err_base, 0);

        // 300 aborted frames saturate the error counter
        for (int i = 0; i < 300; i++) begin
            cs_low();
            send_byte(8'h05);
            cs_high();
        end
        check("sat_cnt", o_Err_Count, 8'hFF);
        check("no_double_pulse", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
